split_sample_gen: RTL and testbench

- Candidate-assignment generator: the driving end of the split_N constraint checkers.
- Produces pseudo-random packed variable vectors on `cand` and samples the checker's combinational `x` result on `sat_in`.
- Retries until a satisfying vector is found or the attempt budget is exhausted.
- Returns the accepted vector over a valid/ready handshake. Sits between the solver controller and one split_N instance.

---
 rtl/split_sample_gen.sv | 182 ++++++++++++++++++
 tb/tb_split_sample_gen.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/split_sample_gen.sv
// split_sample_gen
//   Candidate-assignment generator that drives one split_N constraint checker.
//   It builds pseudo-random VEC_W-bit candidates from a 32-bit Galois LFSR, one
//   32-bit word per cycle, and presents each candidate to the checker for one
//   cycle. It retries until the checker accepts a candidate or MAX_TRIES
//   attempts have been used. An accepted vector is returned over a valid/ready
//   handshake.
//
// Parameters
//   VEC_W     : candidate width, a multiple of 32 (minimum 32)
//   MAX_TRIES : attempt budget per start, 1..65535
//   SEED      : LFSR reset value (a value of 0 is replaced by 1)
//
// Ports
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   start       : begin a search (honoured only while idle)
//   seed_load   : load seed_in into the LFSR (idle only, wins over start)
//   seed_in     : new LFSR seed (a value of 0 is replaced by 1)
//   cand        : candidate vector to the checker
//   cand_valid  : candidate is being checked this cycle
//   sat_in      : checker verdict for cand (looked at only while checking)
//   out_valid   : accepted vector available
//   out_ready   : consumer takes out_vec
//   out_vec     : accepted vector
//   out_tries   : attempts used, including the accepted one
//   busy        : search or hand-off in progress
//   fail        : one-cycle pulse when the budget runs out without success
module split_sample_gen #(
  parameter int unsigned VEC_W     = 64,
  parameter int unsigned MAX_TRIES = 256,
  parameter logic [31:0] SEED      = 32'hACE1_2468
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             seed_load,
  input  logic [31:0]      seed_in,
  output logic [VEC_W-1:0] cand,
  output logic             cand_valid,
  input  logic             sat_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] out_vec,
  output logic [15:0]      out_tries,
  output logic             busy,
  output logic             fail
);

  localparam int unsigned WORDS = VEC_W / 32;
  localparam int unsigned IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);
  localparam logic [31:0] LFSR_MASK = 32'h8020_0003;
  localparam logic [31:0] SEED_EFF  = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [15:0] TRY_LIMIT = 16'(MAX_TRIES);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_CHECK,
    S_OUT
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic             fail_d;
  logic [31:0]      lfsr_q;
  logic [31:0]      lfsr_next;
  logic [VEC_W-1:0] cand_q;
  logic [VEC_W-1:0] cand_shift;
  logic [15:0]      tries_q;
  logic [IDX_W-1:0] fill_idx_q;
  logic             fail_q;
  logic             fill_last;

  assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_MASK : 32'h0);
  assign fill_last = (fill_idx_q == LAST_IDX);

  // New words enter at the MSB end, so the first word generated ends up in
  // the least-significant 32 bits once the fill completes.
  generate
    if (WORDS == 1) begin : g_one_word
      assign cand_shift = lfsr_next;
    end else begin : g_multi_word
      assign cand_shift = {lfsr_next, cand_q[VEC_W-1:32]};
    end
  endgenerate

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; sat_in is only consulted in S_CHECK so an unknown
  // verdict elsewhere cannot disturb the state.
  always_comb begin
    state_d = state_q;
    fail_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!seed_load && start) begin
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        if (fill_last) begin
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (sat_in) begin
          state_d = S_OUT;
        end else if (tries_q == TRY_LIMIT) begin
          state_d = S_IDLE;
          fail_d  = 1'b1;
        end else begin
          state_d = S_FILL;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Datapath: LFSR, candidate shift register, attempt counter, fail pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q     <= SEED_EFF;
      cand_q     <= '0;
      tries_q    <= '0;
      fill_idx_q <= '0;
      fail_q     <= 1'b0;
    end else begin
      fail_q <= fail_d;
      case (state_q)
        S_IDLE: begin
          if (seed_load) begin
            lfsr_q <= (seed_in == 32'h0) ? 32'h1 : seed_in;
          end else if (start) begin
            tries_q    <= '0;
            fill_idx_q <= '0;
          end
        end
        S_FILL: begin
          cand_q <= cand_shift;
          lfsr_q <= lfsr_next;
          if (fill_last) begin
            // Index wraps here so a retry from S_CHECK starts a fresh fill.
            fill_idx_q <= '0;
            if (tries_q != '1) begin
              tries_q <= tries_q + 16'd1;
            end
          end else begin
            fill_idx_q <= fill_idx_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // out_vec is the candidate register itself: it is frozen outside S_FILL,
  // so it already holds the accepted vector for the whole of S_OUT.
  assign cand       = cand_q;
  assign out_vec    = cand_q;
  assign out_tries  = tries_q;
  assign cand_valid = (state_q == S_CHECK);
  assign out_valid  = (state_q == S_OUT);
  assign busy       = (state_q != S_IDLE);
  assign fail       = fail_q;

endmodule

// File: tb/tb_split_sample_gen.sv
module tb_split_sample_gen;

  localparam int unsigned VEC_W     = 64;
  localparam int unsigned MAX_TRIES = 4;
  localparam logic [31:0] SEED      = 32'hACE1_2468;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             seed_load = 1'b0;
  logic [31:0]      seed_in = 32'h0;
  logic             sat_in = 1'b0;
  logic             out_ready = 1'b0;
  logic [VEC_W-1:0] cand;
  logic             cand_valid;
  logic             out_valid;
  logic [VEC_W-1:0] out_vec;
  logic [15:0]      out_tries;
  logic             busy;
  logic             fail;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_lfsr;
  logic [63:0] basic_vec;

  split_sample_gen #(
    .VEC_W(VEC_W),
    .MAX_TRIES(MAX_TRIES),
    .SEED(SEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .seed_load(seed_load),
    .seed_in(seed_in),
    .cand(cand),
    .cand_valid(cand_valid),
    .sat_in(sat_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_vec(out_vec),
    .out_tries(out_tries),
    .busy(busy),
    .fail(fail)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] lstep(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  // Reference stream: two LFSR words per attempt, first word in the low half.
  task automatic gen_vec(output logic [63:0] v);
    logic [31:0] w1;
    logic [31:0] w2;
    w1 = lstep(m_lfsr);
    w2 = lstep(w1);
    m_lfsr = w2;
    v = {w2, w1};
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    checks++;
    if (cand !== 64'h0) begin
      errors++; $display("FAIL reset_cand got %h exp %h", cand, 64'h0);
    end
    checks++;
    if ({cand_valid, out_valid, busy, fail} !== 4'b0000) begin
      errors++; $display("FAIL reset_flags got %b exp %b", {cand_valid, out_valid, busy, fail}, 4'b0000);
    end
    checks++;
    if (out_tries !== 16'h0) begin
      errors++; $display("FAIL reset_tries got %h exp %h", out_tries, 16'h0);
    end
    tick();
    rst = 1'b0;
    m_lfsr = SEED;
    tick();
  endtask

  task automatic test_basic;
    logic [63:0] exp_v;
    sat_in = 1'b1;
    out_ready = 1'b1;
    gen_vec(exp_v);
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if ({busy, cand_valid} !== 2'b10) begin
      errors++; $display("FAIL basic_cyc1 got %b exp %b", {busy, cand_valid}, 2'b10);
    end
    tick();
    checks++;
    if (cand_valid !== 1'b0) begin
      errors++; $display("FAIL basic_cyc2_cv got %b exp %b", cand_valid, 1'b0);
    end
    tick();
    checks++;
    if (cand_valid !== 1'b1 || cand !== exp_v) begin
      errors++; $display("FAIL basic_check got cv=%b cand=%h exp cv=1 cand=%h", cand_valid, cand, exp_v);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_vec !== exp_v || out_tries !== 16'd1) begin
      errors++; $display("FAIL basic_out got ov=%b vec=%h tries=%0d exp ov=1 vec=%h tries=1", out_valid, out_vec, out_tries, exp_v);
    end
    tick();
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++; $display("FAIL basic_done got %b exp %b", {busy, out_valid}, 2'b00);
    end
    basic_vec = exp_v;
  endtask

  task automatic test_retry;
    logic [63:0] v1, v2, v3;
    int nchk;
    bit done;
    gen_vec(v1);
    gen_vec(v2);
    gen_vec(v3);
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    sat_in = 1'bx;
    nchk = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (out_valid === 1'b1) begin
        done = 1'b1;
      end else if (cand_valid === 1'b1) begin
        nchk++;
        sat_in = (nchk == 3);
      end else begin
        sat_in = 1'bx;
      end
    end
    checks++;
    if (!done || nchk != 3) begin
      errors++; $display("FAIL retry_checks got done=%0d checks=%0d exp done=1 checks=3", done, nchk);
    end
    checks++;
    if (out_vec !== v3 || out_tries !== 16'd3) begin
      errors++; $display("FAIL retry_out got vec=%h tries=%0d exp vec=%h tries=3", out_vec, out_tries, v3);
    end
    sat_in = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL retry_idle got %b exp %b", busy, 1'b0);
    end
  endtask

  task automatic test_exhaust;
    logic [63:0] v;
    int pulses, fails, ovs;
    for (int k = 0; k < 4; k++) gen_vec(v);
    sat_in = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    pulses = 0;
    fails = 0;
    ovs = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (cand_valid === 1'b1) pulses++;
      if (out_valid === 1'b1) ovs++;
      if (fail === 1'b1) begin
        fails++;
        checks++;
        if (busy !== 1'b0) begin
          errors++; $display("FAIL exhaust_fail_busy got %b exp %b", busy, 1'b0);
        end
      end
    end
    checks++;
    if (pulses != 4) begin
      errors++; $display("FAIL exhaust_pulses got %0d exp %0d", pulses, 4);
    end
    checks++;
    if (fails != 1) begin
      errors++; $display("FAIL exhaust_fail_width got %0d exp %0d", fails, 1);
    end
    checks++;
    if (ovs != 0 || busy !== 1'b0) begin
      errors++; $display("FAIL exhaust_end got ov_cycles=%0d busy=%b exp 0 0", ovs, busy);
    end
    checks++;
    if (out_tries !== 16'd4) begin
      errors++; $display("FAIL exhaust_tries got %0d exp %0d", out_tries, 4);
    end
  endtask

  task automatic test_backpressure;
    logic [63:0] exp_v;
    gen_vec(exp_v);
    sat_in = 1'b1;
    out_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20 && out_valid !== 1'b1; i++) tick();
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL bp_timeout got ov=%b exp ov=1", out_valid);
    end
    for (int i = 0; i < 10; i++) begin
      start = i[0];
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_vec !== exp_v || out_tries !== 16'd1) begin
        errors++; $display("FAIL bp_hold cyc=%0d got ov=%b vec=%h tries=%0d exp ov=1 vec=%h tries=1", i, out_valid, out_vec, out_tries, exp_v);
      end
    end
    start = 1'b0;
    out_ready = 1'b1;
    tick();
    checks++;
    if ({busy, out_valid} !== 2'b00) begin
      errors++; $display("FAIL bp_release got %b exp %b", {busy, out_valid}, 2'b00);
    end
  endtask

  task automatic test_seed;
    logic [63:0] exp_v;
    seed_in = 32'h0;
    seed_load = 1'b1;
    start = 1'b1;
    tick();
    seed_load = 1'b0;
    start = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL seed_priority_busy got %b exp %b", busy, 1'b0);
    end
    m_lfsr = 32'h1;
    gen_vec(exp_v);
    sat_in = 1'b1;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (cand_valid !== 1'b1 || cand[31:0] !== 32'h8020_0003) begin
      errors++; $display("FAIL seed_first_word got cv=%b w=%h exp cv=1 w=80200003", cand_valid, cand[31:0]);
    end
    checks++;
    if (cand !== exp_v) begin
      errors++; $display("FAIL seed_vec got %h exp %h", cand, exp_v);
    end
    tick();
    tick();
  endtask

  task automatic test_reset_mid;
    sat_in = 1'b0;
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1;
    checks++;
    if (cand !== 64'h0 || out_vec !== 64'h0 || out_tries !== 16'h0) begin
      errors++; $display("FAIL midrst_data got cand=%h vec=%h tries=%0d exp 0 0 0", cand, out_vec, out_tries);
    end
    checks++;
    if ({cand_valid, out_valid, busy, fail} !== 4'b0000) begin
      errors++; $display("FAIL midrst_flags got %b exp %b", {cand_valid, out_valid, busy, fail}, 4'b0000);
    end
    tick();
    rst = 1'b0;
    tick();
    sat_in = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    checks++;
    if (cand_valid !== 1'b1 || cand !== basic_vec) begin
      errors++; $display("FAIL midrst_rerun got cv=%b cand=%h exp cv=1 cand=%h", cand_valid, cand, basic_vec);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_vec !== basic_vec || out_tries !== 16'd1) begin
      errors++; $display("FAIL midrst_out got ov=%b vec=%h tries=%0d exp ov=1 vec=%h tries=1", out_valid, out_vec, out_tries, basic_vec);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_retry();
    test_exhaust();
    test_backpressure();
    test_seed();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
